// File: rtl/signed_acc_stream.sv
// Streaming signed accumulator: sums each valid/ready packet of WIDTH-bit samples and
// emits sum, sticky overflow and beat count. Define SIGNED_ACC_SAT_EN for saturating steps.
module signed_acc_stream #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count,
  output logic             o_dbg_state
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_overflow;
  logic [CNT_W-1:0] r_out_count;

  logic             w_accept;
  logic             w_close;
  logic             w_consume;
  logic [WIDTH-1:0] w_sum;
  logic             w_step_ovf;
  logic [WIDTH-1:0] w_next_acc;
  logic             w_next_sticky;
  logic [CNT_W-1:0] w_next_count;

  // Handshake: a beat moves when in_valid && in_ready on a rising edge; a result moves when
  // out_valid && out_ready. in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (r_state == ST_ACC) || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = (r_state == ST_HOLD) && out_ready;

  // The accumulator is cleared on every close, so a first beat adds to zero and cannot overflow.
  assign w_sum      = r_acc + in_data;
  assign w_step_ovf = (r_acc[WIDTH-1] == in_data[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

`ifdef SIGNED_ACC_SAT_EN
  always_comb begin
    w_next_acc = w_sum;
    if (w_step_ovf) begin
      // Both operands share a sign; clamp toward that sign's extreme.
      w_next_acc = r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_next_acc = w_sum;
`endif

  assign w_next_sticky = r_sticky | w_step_ovf;
  assign w_next_count  = r_count + CNT_W'(1);
  assign w_close       = w_accept && (in_last || (w_next_count == CNT_W'(MAX_LEN)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_ACC;
      r_acc          <= '0;
      r_sticky       <= 1'b0;
      r_count        <= '0;
      r_out_valid    <= 1'b0;
      r_out_sum      <= '0;
      r_out_overflow <= 1'b0;
      r_out_count    <= '0;
    end else if (w_close) begin
      r_state        <= ST_HOLD;
      r_out_valid    <= 1'b1;
      r_out_sum      <= w_next_acc;
      r_out_overflow <= w_next_sticky;
      r_out_count    <= w_next_count;
      r_acc          <= '0;
      r_sticky       <= 1'b0;
      r_count        <= '0;
    end else begin
      if (w_accept) begin
        r_acc    <= w_next_acc;
        r_sticky <= w_next_sticky;
        r_count  <= w_next_count;
      end
      // Result consumed without a new close: fall back to collecting.
      if (w_consume) begin
        r_state     <= ST_ACC;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_overflow = r_out_overflow;
  assign out_count    = r_out_count;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_signed_acc_stream.sv
// Bench for signed_acc_stream at WIDTH=4, MAX_LEN=4, checked against an integer-range model.
// Build with SIGNED_ACC_SAT_EN defined to check the saturating variant.
module tb_signed_acc_stream;
  localparam int W    = 4;
  localparam int L    = 4;
  localparam int CW   = $clog2(L + 1);
  localparam int EW   = 1 + CW + W;
  localparam int MAXV = (2 ** (W - 1)) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_overflow;
  logic [CW-1:0] out_count;
  logic          dbg_state;

  int total = 0;
  int bad   = 0;

  int m_acc;
  int m_cnt;
  bit m_sticky;
  logic [EW-1:0] exp_q[$];

  signed_acc_stream #(.WIDTH(W), .MAX_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow), .out_count(out_count), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_sticky = 1'b0;
  endtask

  // Reference: exact integer sum, then range check, then wrap or clamp.
  task automatic model_beat(input int d, input bit last);
    int s;
    bit ovf;
    s = m_acc + d;
    ovf = (s > MAXV) || (s < MINV);
`ifdef SIGNED_ACC_SAT_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`else
    if (s > MAXV) s = s - (2 ** W);
    if (s < MINV) s = s + (2 ** W);
`endif
    m_sticky = m_sticky | ovf;
    m_cnt++;
    if (last || m_cnt == L) begin
      exp_q.push_back({m_sticky, CW'(m_cnt), W'(s)});
      model_reset();
    end else begin
      m_acc = s;
    end
  endtask

  // driver: present one beat and wait (bounded) for its acceptance
  task automatic send_beat(input int d, input bit last);
    bit seen;
    logic [31:0] dv;
    seen = 1'b0;
    dv = d;
    in_valid = 1'b1;
    in_data = dv[W-1:0];
    in_last = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      #1;
      if (seen) break;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: beat %0d not accepted within 50 cycles", d);
    end else begin
      model_beat(d, last);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_overflow, out_count, out_sum} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, out_overflow, out_count, out_sum});
    end
    total++;
    if (in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got ready=%b state=%b want ready=1 state=0", in_ready, dbg_state);
    end
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic test_directed();
    int beats[$];
    int es;
    int ec;
    bit eo;
    logic [EW-1:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin beats = '{3, 5};
`ifdef SIGNED_ACC_SAT_EN
             es = 7;
`else
             es = -8;
`endif
             eo = 1'b1; end
        1: begin beats = '{7, 1, -2};
`ifdef SIGNED_ACC_SAT_EN
             es = 5;
`else
             es = 6;
`endif
             eo = 1'b1; end
        2: begin beats = '{-8, -1};
`ifdef SIGNED_ACC_SAT_EN
             es = -8;
`else
             es = 7;
`endif
             eo = 1'b1; end
        default: begin beats = '{-3, 6}; es = 3; eo = 1'b0; end
      endcase
      ec = beats.size();
      for (int i = 0; i < ec; i++) send_beat(beats[i], i == ec - 1);
      total++;
      if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, eo, CW'(ec), W'(es)}) begin
        bad++;
        $display("FAIL directed_%0d: got %h want %h", c,
                 {out_valid, out_overflow, out_count, out_sum}, {1'b1, eo, CW'(ec), W'(es)});
      end
      e = exp_q.pop_front();
      total++;
      if ({out_overflow, out_count, out_sum} !== e) begin
        bad++;
        $display("FAIL directed_model_%0d: got %h want %h", c, {out_overflow, out_count, out_sum}, e);
      end
      idle(1);
      total++;
      if (out_valid !== 1'b0 || dbg_state !== 1'b0) begin
        bad++;
        $display("FAIL directed_consume_%0d: got valid=%b state=%b want 0 0", c, out_valid, dbg_state);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e;
    out_ready = 1'b0;
    send_beat(1, 1'b0);
    send_beat(2, 1'b1);
    e = exp_q.pop_front();
    in_valid = 1'b1;
    in_data = W'(3);
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_overflow, out_count, out_sum} !== e
          || e !== {1'b0, CW'(2), W'(3)}) begin
        bad++;
        $display("FAIL backpressure_hold_%0d: got ready=%b valid=%b out=%h want 0 1 %h", i,
                 in_ready, out_valid, {out_overflow, out_count, out_sum}, {1'b0, CW'(2), W'(3)});
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(3, 1'b0);
    total++;
    if (out_valid !== 1'b0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release: got valid=%b state=%b want 0 0", out_valid, dbg_state);
    end
    send_beat(4, 1'b1);
    e = exp_q.pop_front();
    total++;
    if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, 1'b0, CW'(2), W'(7)}
        || e !== {1'b0, CW'(2), W'(7)}) begin
      bad++;
      $display("FAIL backpressure_next: got %h want %h", {out_valid, out_overflow, out_count, out_sum},
               {1'b1, 1'b0, CW'(2), W'(7)});
    end
    idle(1);
  endtask

  task automatic test_forced_close();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(1, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL forced_early: got valid=%b want 0", out_valid);
    end
    send_beat(1, 1'b0);
    void'(exp_q.pop_front());
    total++;
    if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, 1'b0, CW'(4), W'(4)}) begin
      bad++;
      $display("FAIL forced_close: got %h want %h", {out_valid, out_overflow, out_count, out_sum},
               {1'b1, 1'b0, CW'(4), W'(4)});
    end
    send_beat(5, 1'b1);
    void'(exp_q.pop_front());
    total++;
    if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, 1'b0, CW'(1), W'(5)}) begin
      bad++;
      $display("FAIL forced_next: got %h want %h", {out_valid, out_overflow, out_count, out_sum},
               {1'b1, 1'b0, CW'(1), W'(5)});
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int d[$];
    bit lst[$];
    logic [EW-1:0] e;
    realtime t0;
    d = '{1, 2, 3, -1, 6, -7, 4, 4};
    lst = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    t0 = $realtime;
    for (int i = 0; i < d.size(); i++) begin
      send_beat(d[i], lst[i]);
      if (lst[i]) begin
        e = exp_q.pop_front();
        total++;
        if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, e}) begin
          bad++;
          $display("FAIL back_to_back_%0d: got %h want %h", i,
                   {out_valid, out_overflow, out_count, out_sum}, {1'b1, e});
        end
      end
    end
    total++;
    if ($realtime - t0 != 10.0 * d.size()) begin
      bad++;
      $display("FAIL back_to_back_rate: got %0t want %0d beats x 10", $realtime - t0, d.size());
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_beat(5, 1'b0);
    send_beat(6, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    total++;
    if (out_valid !== 1'b0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: got valid=%b state=%b want 0 0", out_valid, dbg_state);
    end
    send_beat(2, 1'b1);
    void'(exp_q.pop_front());
    total++;
    if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, 1'b0, CW'(1), W'(2)}) begin
      bad++;
      $display("FAIL reset_mid_packet: got %h want %h", {out_valid, out_overflow, out_count, out_sum},
               {1'b1, 1'b0, CW'(1), W'(2)});
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [EW-1:0] e;
    int d;
    bit lst;
    int hold;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d = int'($urandom_range(0, 2 ** W - 1)) + MINV;
      lst = ($urandom_range(0, 3) == 0);
      send_beat(d, lst);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, e}) begin
          bad++;
          $display("FAIL random_%0d: got %h want %h", i,
                   {out_valid, out_overflow, out_count, out_sum}, {1'b1, e});
        end
        hold = $urandom_range(0, 2);
        if (hold > 0) begin
          out_ready = 1'b0;
          in_valid = 1'b0;
          repeat (hold) @(posedge clk);
          #1;
          total++;
          if ({out_valid, out_overflow, out_count, out_sum} !== {1'b1, e}) begin
            bad++;
            $display("FAIL random_stable_%0d: got %h want %h", i,
                     {out_valid, out_overflow, out_count, out_sum}, {1'b1, e});
          end
          out_ready = 1'b1;
        end
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_forced_close();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
